// File: rtl/data_samp_pkg.sv
// Shared constants and helpers for the majority-vote UART RX data sampler.
package data_samp_pkg;

    localparam int MAX_SAMPLES = 7;

    function automatic int samp_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Odd sample counts only, so the vote can never tie.
    function automatic bit samp_num_ok(input int n);
        return (n >= 1) && (n <= MAX_SAMPLES) && ((n % 2) == 1);
    endfunction

endpackage

// File: rtl/data_samp_window.sv
// Combinational decode of the sampling window and decision edge from edge_cnt/prescale.
module data_samp_window
    import data_samp_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3
) (
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  in_window,
    output logic                  at_decision
);

    localparam int W    = PRESCALE_W + 1;
    localparam int HALF = (NUM_SAMPLES - 1) / 2;

    // One extra bit of headroom keeps center+HALF and prescale-2 from wrapping.
    logic [W-1:0] ps, ec, center, lo, hi, dec;

    assign ps          = {1'b0, prescale};
    assign ec          = {1'b0, edge_cnt};
    assign center      = (ps >> 1) - W'(1);
    assign lo          = center - W'(HALF);
    assign hi          = center + W'(HALF);
    assign dec         = ps - W'(2);
    assign in_window   = (ec >= lo) && (ec <= hi);
    assign at_decision = (ec == dec);

endmodule

// File: rtl/data_sampling_rx_mv.sv
// UART RX data sampler: majority vote over NUM_SAMPLES centred samples, one-cycle valid strobe.
// Optional noise flag on non-unanimous bits is built only when DATA_SAMP_NOISE_EN is defined.
module data_sampling_rx_mv
    import data_samp_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3
) (
    input  logic                  CLK_SAM,
    input  logic                  RST_SAM,
    input  logic                  RX_IN,
    input  logic                  data_samp_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sample_bit_samp,
    output logic                  sample_valid,
    output logic                  noise_err
);

    generate
        if (!samp_num_ok(NUM_SAMPLES)) begin : g_bad_num_samples
            $error("NUM_SAMPLES must be odd and in 1..%0d", MAX_SAMPLES);
        end
    endgenerate

    localparam int                CNT_W = samp_cnt_w(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] MAJ   = CNT_W'(NUM_SAMPLES / 2);

    logic             in_window, at_decision;
    logic [CNT_W-1:0] ones;

    data_samp_window #(
        .PRESCALE_W (PRESCALE_W),
        .NUM_SAMPLES(NUM_SAMPLES)
    ) u_window (
        .edge_cnt   (edge_cnt),
        .prescale   (prescale),
        .in_window  (in_window),
        .at_decision(at_decision)
    );

    // Disable behaves exactly like reset so a dropped bit leaves no stale count.
    always_ff @(posedge CLK_SAM) begin
        if (!RST_SAM || !data_samp_en) begin
            ones            <= '0;
            sample_bit_samp <= 1'b1;
            sample_valid    <= 1'b0;
        end else if (at_decision) begin
            sample_bit_samp <= (ones > MAJ);
            sample_valid    <= 1'b1;
            ones            <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (in_window && (ones != FULL))
                ones <= ones + CNT_W'(RX_IN);
        end
    end

`ifdef DATA_SAMP_NOISE_EN
    always_ff @(posedge CLK_SAM) begin
        if (!RST_SAM || !data_samp_en)
            noise_err <= 1'b0;
        else if (at_decision)
            noise_err <= (ones != '0) && (ones != FULL);
    end
`else
    assign noise_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_sampling_rx_mv.sv
// Bench for data_sampling_rx_mv: 3- and 5-sample instances against a per-bit sample-list model.
module tb_data_sampling_rx_mv;

`ifdef DATA_SAMP_NOISE_EN
    localparam bit NOISE = 1'b1;
`else
    localparam bit NOISE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, rx, en;
    logic [5:0] ec, ps;
    logic       b3, v3, n3, b5, v5, n5;

    int cmp  = 0;
    int fail = 0;

    // Model state: samples taken in the current bit, plus expected outputs.
    int   ns[2] = '{3, 5};
    bit   samp_q[2][$];
    logic exp_bit[2], exp_vld[2], exp_nz[2];

    always #5 clk = ~clk;

    data_sampling_rx_mv #(.PRESCALE_W(6), .NUM_SAMPLES(3)) u3 (
        .CLK_SAM(clk), .RST_SAM(rst_n), .RX_IN(rx), .data_samp_en(en),
        .edge_cnt(ec), .prescale(ps),
        .sample_bit_samp(b3), .sample_valid(v3), .noise_err(n3)
    );

    data_sampling_rx_mv #(.PRESCALE_W(6), .NUM_SAMPLES(5)) u5 (
        .CLK_SAM(clk), .RST_SAM(rst_n), .RX_IN(rx), .data_samp_en(en),
        .edge_cnt(ec), .prescale(ps),
        .sample_bit_samp(b5), .sample_valid(v5), .noise_err(n5)
    );

    // Drive one cycle from the negedge, advance the model, return at the next negedge.
    task automatic step(input bit r, input bit e_n, input int e, input bit x, input int p);
        rst_n = r; en = e_n; ec = 6'(e); ps = 6'(p); rx = x;
        for (int k = 0; k < 2; k++) begin
            int n, c, h, cnt;
            n = ns[k]; c = p / 2 - 1; h = (n - 1) / 2; cnt = 0;
            if (!r || !e_n) begin
                exp_bit[k] = 1'b1; exp_vld[k] = 1'b0; exp_nz[k] = 1'b0;
                samp_q[k].delete();
            end else if (e == p - 2) begin
                foreach (samp_q[k][i]) cnt += int'(samp_q[k][i]);
                if (cnt > n) cnt = n;
                exp_bit[k] = (2 * cnt > n);
                exp_nz[k]  = NOISE && (cnt != 0) && (cnt != n);
                exp_vld[k] = 1'b1;
                samp_q[k].delete();
            end else begin
                if (e >= c - h && e <= c + h) samp_q[k].push_back(x);
                exp_vld[k] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(0, 1, 0, 0, 8);
        step(0, 0, 0, 0, 8);
        cmp++;
        if ({b3, v3, n3, b5, v5, n5} !== 6'b100100) begin
            fail++;
            $display("FAIL reset outputs got %b%b%b/%b%b%b required 100/100", b3, v3, n3, b5, v5, n5);
        end
    endtask

    task automatic test_clean_bit();
        for (int e = 0; e < 8; e++) begin
            step(1, 1, e, 0, 8);
            cmp++;
            if ({v3, b3, n3} !== {exp_vld[0], exp_bit[0], exp_nz[0]}) begin
                fail++;
                $display("FAIL clean_bit e=%0d got v/b/n=%b%b%b required %b%b%b",
                         e, v3, b3, n3, exp_vld[0], exp_bit[0], exp_nz[0]);
            end
            if (e == 6) begin
                cmp++;
                if ({v3, b3, n3} !== 3'b100) begin
                    fail++;
                    $display("FAIL clean_bit_strobe got v/b/n=%b%b%b required 100", v3, b3, n3);
                end
            end
        end
    endtask

    task automatic test_glitch();
        step(0, 0, 0, 1, 16);
        for (int e = 0; e < 16; e++) begin
            step(1, 1, e, (e != 7), 16);
            if (e == 14) begin
                cmp++;
                if ({v5, b5, n5} !== {2'b11, NOISE}) begin
                    fail++;
                    $display("FAIL glitch5 got v/b/n=%b%b%b required 11%b", v5, b5, n5, NOISE);
                end
                cmp++;
                if ({v3, b3, n3} !== {exp_vld[0], exp_bit[0], exp_nz[0]}) begin
                    fail++;
                    $display("FAIL glitch3 got v/b/n=%b%b%b required %b%b%b",
                             v3, b3, n3, exp_vld[0], exp_bit[0], exp_nz[0]);
                end
            end
        end
    endtask

    task automatic test_two_of_three();
        step(0, 0, 0, 1, 32);
        for (int e = 0; e < 32; e++) begin
            bit x;
            x = (e == 14 || e == 16) ? 1'b0 : (e == 15) ? 1'b1 : 1'($urandom_range(1));
            step(1, 1, e, x, 32);
            if (e == 30) begin
                cmp++;
                if ({v3, b3, n3} !== {2'b10, NOISE}) begin
                    fail++;
                    $display("FAIL two_of_three got v/b/n=%b%b%b required 10%b", v3, b3, n3, NOISE);
                end
                cmp++;
                if ({v5, b5, n5} !== {exp_vld[1], exp_bit[1], exp_nz[1]}) begin
                    fail++;
                    $display("FAIL two_of_three5 got v/b/n=%b%b%b required %b%b%b",
                             v5, b5, n5, exp_vld[1], exp_bit[1], exp_nz[1]);
                end
            end
        end
    endtask

    task automatic test_min_prescale();
        bit bits[3] = '{1'b1, 1'b0, 1'b1};
        int strobes = 0;
        step(0, 0, 0, 1, 6);
        for (int b = 0; b < 3; b++) begin
            for (int e = 0; e < 6; e++) begin
                step(1, 1, e, bits[b], 6);
                strobes += int'(v3);
                cmp++;
                if ({v3, b3} !== {exp_vld[0], exp_bit[0]}) begin
                    fail++;
                    $display("FAIL min_prescale bit=%0d e=%0d got v/b=%b%b required %b%b",
                             b, e, v3, b3, exp_vld[0], exp_bit[0]);
                end
                if (e == 4) begin
                    cmp++;
                    if ({v3, b3} !== {1'b1, bits[b]}) begin
                        fail++;
                        $display("FAIL min_prescale_val bit=%0d got v/b=%b%b required 1%b", b, v3, b3, bits[b]);
                    end
                end
            end
        end
        cmp++;
        if (strobes != 3) begin
            fail++;
            $display("FAIL min_prescale_strobes got %0d required 3", strobes);
        end
    endtask

    task automatic test_disable_mid_bit();
        step(0, 0, 0, 1, 6);
        for (int e = 0; e < 3; e++) step(1, 1, e, 1, 6);
        for (int e = 3; e < 6; e++) begin
            step(1, 0, e, 1, 6);
            cmp++;
            if ({b3, v3} !== 2'b10) begin
                fail++;
                $display("FAIL disabled e=%0d got b/v=%b%b required 10", e, b3, v3);
            end
        end
        for (int e = 0; e < 6; e++) begin
            step(1, 1, e, 0, 6);
            if (e == 4) begin
                cmp++;
                if ({v3, b3} !== 2'b10) begin
                    fail++;
                    $display("FAIL reenable got v/b=%b%b required 10", v3, b3);
                end
            end
        end
    endtask

    task automatic test_reset_mid_bit();
        step(0, 0, 0, 1, 8);
        for (int e = 0; e < 3; e++) step(1, 1, e, 1, 8);
        step(0, 1, 3, 1, 8);
        cmp++;
        if ({b3, v3, n3, b5, v5, n5} !== 6'b100100) begin
            fail++;
            $display("FAIL reset_mid_bit got %b%b%b/%b%b%b required 100/100", b3, v3, n3, b5, v5, n5);
        end
        for (int e = 0; e < 8; e++) begin
            step(1, 1, e, (e == 2), 8);
            if (e == 6) begin
                cmp++;
                if ({v3, b3, v5, b5} !== 4'b1010) begin
                    fail++;
                    $display("FAIL after_reset got v3/b3/v5/b5=%b%b%b%b required 1010", v3, b3, v5, b5);
                end
            end
        end
    endtask

    task automatic test_random();
        int pss[3] = '{8, 16, 32};
        for (int b = 0; b < 40; b++) begin
            int p;
            p = pss[$urandom_range(2)];
            for (int e = 0; e < p; e++) begin
                step(1, ($urandom_range(29) != 0), e, 1'($urandom_range(1)), p);
                cmp++;
                if ({v3, b3, n3, v5, b5, n5} !== {exp_vld[0], exp_bit[0], exp_nz[0],
                                                  exp_vld[1], exp_bit[1], exp_nz[1]}) begin
                    fail++;
                    $display("FAIL random p=%0d e=%0d got %b%b%b/%b%b%b required %b%b%b/%b%b%b",
                             p, e, v3, b3, n3, v5, b5, n5, exp_vld[0], exp_bit[0], exp_nz[0],
                             exp_vld[1], exp_bit[1], exp_nz[1]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; rx = 1'b1; ec = '0; ps = 6'd8;
        @(negedge clk);
        test_reset();
        test_clean_bit();
        test_glitch();
        test_two_of_three();
        test_min_prescale();
        test_disable_mid_bit();
        test_reset_mid_bit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end

endmodule
